cv32e40p_ft_recovery_ctrl: RTL and testbench
============================================

# cv32e40p_ft_recovery_ctrl

Recovery sequencer for the triplicated fault-tolerant aligner. It consumes the per-replica mismatch flags produced by the aligner's output voters and keeps a leaky-bucket error score for each replica. It decides when a replica is permanently broken and drives that decision back into the aligner. It also sequences a flush/resync of the instruction-fetch front end after every detected error, and escalates to a sticky fatal state when redundancy is exhausted.

## Interface
Parameters:
- INCREMENT, 4: score added per cycle a replica mismatches.
- DECREMENT, 1: score removed per cycle a replica agrees.
- THRESHOLD, 16: score at or above which a replica is declared broken.
- COUNT_BIT, 5: score width; the score saturates at 2^COUNT_BIT-1.
- ACK_TIMEOUT, 15: maximum cycles FLUSH waits for `flush_ack_i`.
- RESYNC_CYCLES, 2: cycles `resync_o` is held high.

Ports:
- clk  in  1  clock, all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- block_err_i  in  3  per-replica mismatch from the aligner voters (OR over all voted outputs).
- force_broken_i  in  3  software/debug request to declare a replica broken.
- flush_ack_i  in  1  the front end has completed the flush.
- is_broken_o  out  3  sticky broken flag per replica; feeds the aligner's `broken_block_i` / `set_broken_i`.
- flush_req_o  out  1  flush request to the fetch stage.
- resync_o  out  1  all replicas reloading from a common fetch point; voter errors are ignored.
- fatal_o  out  1  sticky uncorrectable condition.
- state_o  out  2  FSM state: IDLE=0, FLUSH=1, RESYNC=2, FAULT=3.
- recovery_cnt_o  out  8  completed recoveries, saturating at 255.

## Operation
Error filtering:
- `err_eff[i] = block_err_i[i] & ~is_broken_o[i] & ~resync_o`.

Scores (per replica):
- If `err_eff[i]`: `score[i] <= min(score[i]+INCREMENT, 2^COUNT_BIT-1)`.
- Otherwise: `score[i] <= max(score[i]-DECREMENT, 0)`.
- Arithmetic is done on COUNT_BIT+1 bits before clamping.
- Once a replica is broken its score freezes.

Broken flags:
- `is_broken_o[i]` is set on the same edge where the next score is >= THRESHOLD, or where `force_broken_i[i]=1`.
- It is sticky until `rst`.

FSM:
- IDLE: if any `err_eff`, go to FLUSH.
- FLUSH: `flush_req_o=1`. Timer counts from 0. If `flush_ack_i`, go to RESYNC. If the timer reaches ACK_TIMEOUT with no ack, go to FAULT.
- RESYNC: `resync_o=1` for exactly RESYNC_CYCLES cycles, then go to IDLE and increment `recovery_cnt_o` (saturating).
- FAULT: `fatal_o=1` and `flush_req_o=0`. Absorbing until `rst`.
- Global override: the FSM goes to FAULT from any state when either:
  - the popcount of the next `is_broken_o` is >= 2, or
  - `err_eff` has >= 2 bits set in a single cycle (the vote is not trustworthy).

Errors during FLUSH or RESYNC:
- In FLUSH they still update scores but do not restart the sequence.
- In RESYNC they are masked entirely.

## Timing
Reset values:
- `is_broken_o=0`, all scores 0.
- `flush_req_o=0`, `resync_o=0`, `fatal_o=0`.
- `state_o=0`, `recovery_cnt_o=0`.

Latencies:
- Error sampled at edge N gives `flush_req_o=1` and the updated score/`is_broken_o` after edge N.
- `flush_ack_i` sampled high at edge M gives `flush_req_o=0` and `resync_o=1` after M, then `state_o=0` after edge M+RESYNC_CYCLES.
- The ack is a level, sampled only in FLUSH. An ack arriving in the same cycle the request rises completes FLUSH in one cycle.

Edge cases:
- Timeout: FAULT is entered after edge ACK_TIMEOUT+1 of FLUSH if no ack arrives.
- Asserting `rst` mid-sequence clears everything asynchronously, including the broken flags.
- Simultaneous threshold crossing and ack: the FAULT override wins only if two replicas are broken. Otherwise RESYNC proceeds.
- `force_broken_i` on an already-broken replica has no effect.

## Test plan
- Single transient: `block_err_i=3'b010` for 1 cycle, ack 2 cycles later. Expect FLUSH for 3 cycles, RESYNC for 2, back to IDLE, score[1]=4 decaying to 0 over 4 cycles, `recovery_cnt_o=1`.
- Persistent replica: `block_err_i=3'b010` for 4 consecutive cycles. Expect scores 4, 8, 12, 16 and `is_broken_o=3'b010` after the 4th edge. Further errors on replica 1 are ignored and the score stays 16.
- Double error: `block_err_i=3'b011` in one cycle. Expect `state_o=3`, `fatal_o=1` next cycle, persisting until `rst`.
- Ack timeout: single error with `flush_ack_i` held 0. Expect `fatal_o=1` after 16 FLUSH cycles and `flush_req_o` deasserted.
- Forced break: `force_broken_i=3'b001`, then a later error on replica 2. Expect `is_broken_o=3'b101` and FAULT. Then assert `rst` mid-FAULT and expect every output back to its reset value.
- Counter saturation: 256 isolated recoveries with immediate ack. Expect `recovery_cnt_o` to hold at 255.

Source files
------------

// File: rtl/cv32e40p_ft_recovery_ctrl_if.sv
// Signal bundle between the recovery sequencer, the TMR aligner voters and the fetch front end.
// The controller takes the slave view; the aligner/front-end side takes the master view.
interface cv32e40p_ft_recovery_ctrl_if;
  logic [2:0] block_err_i;
  logic [2:0] force_broken_i;
  logic       flush_ack_i;
  logic [2:0] is_broken_o;
  logic       flush_req_o;
  logic       resync_o;
  logic       fatal_o;
  logic [1:0] state_o;
  logic [7:0] recovery_cnt_o;

  modport slave (
    input  block_err_i, force_broken_i, flush_ack_i,
    output is_broken_o, flush_req_o, resync_o, fatal_o, state_o, recovery_cnt_o
  );

  modport master (
    output block_err_i, force_broken_i, flush_ack_i,
    input  is_broken_o, flush_req_o, resync_o, fatal_o, state_o, recovery_cnt_o
  );
endinterface

// File: rtl/cv32e40p_ft_recovery_ctrl.sv
// Recovery sequencer for the triplicated aligner: leaky-bucket scoring per replica,
// sticky broken flags, and a flush/resync FSM that escalates to a sticky fatal state.
module cv32e40p_ft_recovery_ctrl #(
  parameter int unsigned INCREMENT     = 4,
  parameter int unsigned DECREMENT     = 1,
  parameter int unsigned THRESHOLD     = 16,
  parameter int unsigned COUNT_BIT     = 5,
  parameter int unsigned ACK_TIMEOUT   = 15,
  parameter int unsigned RESYNC_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  cv32e40p_ft_recovery_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    RESYNC = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam int unsigned TIMER_MAX = (ACK_TIMEOUT > RESYNC_CYCLES) ? ACK_TIMEOUT : RESYNC_CYCLES;
  localparam int unsigned TW        = $clog2(TIMER_MAX + 2);

  localparam logic [COUNT_BIT:0] INC_W   = (COUNT_BIT + 1)'(INCREMENT);
  localparam logic [COUNT_BIT:0] DEC_W   = (COUNT_BIT + 1)'(DECREMENT);
  localparam logic [COUNT_BIT:0] THR_W   = (COUNT_BIT + 1)'(THRESHOLD);
  localparam logic [COUNT_BIT:0] SAT_W   = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [TW-1:0]      TO_W    = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0]      RS_LAST = TW'(RESYNC_CYCLES - 1);

  state_e                       state_q, state_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [2:0][COUNT_BIT-1:0]    score_q, score_d;
  logic [2:0]                   broken_q, broken_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic [2:0]                   err_eff;
  logic                         in_resync;

  // Saturating add / floored subtract done one bit wider than the score.
  function automatic logic [COUNT_BIT-1:0] next_score(input logic [COUNT_BIT-1:0] s,
                                                       input logic              err);
    logic [COUNT_BIT:0] wide;
    logic [COUNT_BIT:0] res;
    wide = {1'b0, s};
    if (err) begin
      res = wide + INC_W;
      if (res > SAT_W) res = SAT_W;
    end else begin
      res = (wide > DEC_W) ? (wide - DEC_W) : '0;
    end
    return res[COUNT_BIT-1:0];
  endfunction

  function automatic logic two_or_more(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  assign in_resync = (state_q == RESYNC);
  assign err_eff   = bus.block_err_i & ~broken_q & {3{~in_resync}};

  always_comb begin
    score_d  = score_q;
    broken_d = broken_q | bus.force_broken_i;
    for (int i = 0; i < 3; i++) begin
      if (!broken_q[i]) begin
        score_d[i] = next_score(score_q[i], err_eff[i]);
        if ({1'b0, score_d[i]} >= THR_W) broken_d[i] = 1'b1;
      end
    end
  end

  // The untrusted-vote / exhausted-redundancy override is applied last so it beats every state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|err_eff) begin
          state_d = FLUSH;
          timer_d = '0;
        end
      end
      FLUSH: begin
        if (bus.flush_ack_i) begin
          state_d = RESYNC;
          timer_d = '0;
        end else if (timer_q == TO_W) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESYNC: begin
        if (timer_q == RS_LAST) begin
          state_d = IDLE;
          timer_d = '0;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    if (two_or_more(broken_d) || two_or_more(err_eff)) begin
      state_d = FAULT;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      score_q  <= '0;
      broken_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      broken_q <= broken_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.is_broken_o    = broken_q;
  assign bus.flush_req_o    = (state_q == FLUSH);
  assign bus.resync_o       = in_resync;
  assign bus.fatal_o        = (state_q == FAULT);
  assign bus.state_o        = state_q;
  assign bus.recovery_cnt_o = cnt_q;

endmodule

// File: tb/tb_cv32e40p_ft_recovery_ctrl.sv
// Directed bench for the recovery sequencer: a vector table for transient/persistent
// errors plus hand-written sequences for timeout, double error, forced break and saturation.
module tb_cv32e40p_ft_recovery_ctrl;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  cv32e40p_ft_recovery_ctrl_if bus();

  cv32e40p_ft_recovery_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] err;
    logic [2:0] force_b;
    logic       ack;
    logic [2:0] exp_broken;
    logic       exp_fr;
    logic       exp_rs;
    logic       exp_fatal;
    logic [1:0] exp_state;
    logic [7:0] exp_cnt;
    logic [4:0] exp_s1;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] err, input logic [2:0] force_b, input logic ack);
    bus.block_err_i    = err;
    bus.force_broken_i = force_b;
    bus.flush_ack_i    = ack;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] br, input logic fr, input logic rs,
                          input logic fatal, input logic [1:0] st, input logic [7:0] cnt);
    checkOutput({tag, ".is_broken"}, 32'(bus.is_broken_o), 32'(br));
    checkOutput({tag, ".flush_req"}, 32'(bus.flush_req_o), 32'(fr));
    checkOutput({tag, ".resync"}, 32'(bus.resync_o), 32'(rs));
    checkOutput({tag, ".fatal"}, 32'(bus.fatal_o), 32'(fatal));
    checkOutput({tag, ".state"}, 32'(bus.state_o), 32'(st));
    checkOutput({tag, ".recovery_cnt"}, 32'(bus.recovery_cnt_o), 32'(cnt));
  endtask

  task automatic doReset();
    applyStimulus(3'b000, 3'b000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    applyStimulus(3'b000, 3'b000, 1'b0);

    //            err     force   ack   broken  fr    rs    fatal st    cnt   s1
    vecs[0]  = '{3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, 5'd4};
    vecs[1]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, 5'd3};
    vecs[2]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, 5'd2};
    vecs[3]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0, 5'd1};
    vecs[4]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0, 5'd0};
    vecs[5]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 5'd0};
    vecs[6]  = '{3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 5'd4};
    vecs[7]  = '{3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 5'd8};
    vecs[8]  = '{3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 5'd12};
    vecs[9]  = '{3'b010, 3'b000, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 2'd2, 8'd1, 5'd16};
    vecs[10] = '{3'b101, 3'b000, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 2'd2, 8'd1, 5'd16};
    vecs[11] = '{3'b101, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2, 5'd16};
    vecs[12] = '{3'b010, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2, 5'd16};
    vecs[13] = '{3'b001, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 2'd1, 8'd2, 5'd16};
    vecs[14] = '{3'b000, 3'b000, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 2'd2, 8'd2, 5'd16};
    vecs[15] = '{3'b000, 3'b010, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 2'd2, 8'd2, 5'd16};
    vecs[16] = '{3'b000, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 8'd3, 5'd16};

    tick();
    tick();
    rst = 1'b0;
    #1;
    checkAll("reset", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    checkOutput("reset.score1", 32'(dut.score_q[1]), 32'd0);

    // Transient error, persistent replica, masking in RESYNC, and a forced request on a broken replica.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].err, vecs[i].force_b, vecs[i].ack);
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].exp_broken, vecs[i].exp_fr, vecs[i].exp_rs,
               vecs[i].exp_fatal, vecs[i].exp_state, vecs[i].exp_cnt);
      checkOutput($sformatf("vec%0d.score1", i), 32'(dut.score_q[1]), 32'(vecs[i].exp_s1));
    end

    // Double error in one cycle is an untrusted vote: straight to FAULT, sticky.
    doReset();
    applyStimulus(3'b011, 3'b000, 1'b0);
    tick();
    checkAll("double", 3'b000, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
    applyStimulus(3'b000, 3'b000, 1'b1);
    repeat (5) tick();
    checkAll("double_sticky", 3'b000, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);

    // Ack never arrives: 16 FLUSH cycles, then FAULT with the request dropped.
    doReset();
    applyStimulus(3'b001, 3'b000, 1'b0);
    tick();
    checkAll("timeout_enter", 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0);
    applyStimulus(3'b000, 3'b000, 1'b0);
    repeat (15) tick();
    checkAll("timeout_last_flush", 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0);
    tick();
    checkAll("timeout_fault", 3'b000, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);

    // Forced break on replica 0, then replica 2 accumulates to the threshold: two broken means FAULT.
    doReset();
    applyStimulus(3'b000, 3'b001, 1'b0);
    tick();
    checkAll("force0", 3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    applyStimulus(3'b100, 3'b000, 1'b0);
    repeat (3) tick();
    checkAll("force_r2_12", 3'b001, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0);
    checkOutput("force_r2_score", 32'(dut.score_q[2]), 32'd12);
    tick();
    checkAll("force_r2_broken", 3'b101, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
    applyStimulus(3'b000, 3'b001, 1'b0);
    tick();
    checkAll("force_again", 3'b101, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
    #3;
    rst = 1'b1;
    #1;
    checkAll("async_reset", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    checkOutput("async_reset.score2", 32'(dut.score_q[2]), 32'd0);
    applyStimulus(3'b000, 3'b000, 1'b0);
    tick();
    rst = 1'b0;
    #1;

    // 256 isolated recoveries with the ack already high; the count must stop at 255.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(3'(1 << (i % 3)), 3'b000, 1'b1);
      tick();
      applyStimulus(3'b000, 3'b000, 1'b1);
      tick();
      if (i == 0) checkAll("sat_first_resync", 3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0);
      applyStimulus(3'b000, 3'b000, 1'b0);
      tick();
      tick();
      tick();
      if (i == 0) checkAll("sat_first_done", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
      if (i == 254) checkAll("sat_255", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd255);
    end
    checkAll("sat_hold", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
